// File: rtl/glyph_serializer_pkg.sv
// Constants shared across the text-mode video path: glyph and colour widths,
// the serializer FSM encoding and default colours.
package glyph_serializer_pkg;

    localparam int DEF_CHAR_W  = 10;
    localparam int DEF_COLOR_W = 8;
    localparam int DEF_CNT_W   = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PRIME = 2'd1;
    localparam state_t ST_READY = 2'd2;
    localparam state_t ST_RUN   = 2'd3;

    localparam logic [7:0] COLOR_BLACK = 8'h00;
    localparam logic [7:0] COLOR_WHITE = 8'hFF;

    // Column counter step: counts 0..limit-1 and wraps back to 0.
    function automatic int wrap_inc(input int col, input int limit);
        return (col >= limit - 1) ? 0 : col + 1;
    endfunction

endpackage

// File: rtl/glyph_shift_reg.sv
// Parallel-load, MSB-first glyph row shifter that carries the cell's FG/BG.
// The current pixel bit and colours are valid in the load cycle itself.
module glyph_shift_reg #(
    parameter int CHAR_W  = 10,
    parameter int COLOR_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               shift_i,
    input  logic [CHAR_W-1:0]  row_i,
    input  logic [COLOR_W-1:0] fg_i,
    input  logic [COLOR_W-1:0] bg_i,
    output logic               pixel_bit_o,
    output logic [COLOR_W-1:0] fg_o,
    output logic [COLOR_W-1:0] bg_o
);

    logic [CHAR_W-1:0]  row_q, row_d;
    logic [COLOR_W-1:0] fg_q, fg_d;
    logic [COLOR_W-1:0] bg_q, bg_d;

    // On load the leftmost pixel is consumed immediately, so store the row pre-shifted.
    always_comb begin
        row_d = row_q;
        fg_d  = fg_q;
        bg_d  = bg_q;
        if (load_i) begin
            row_d = row_i << 1;
            fg_d  = fg_i;
            bg_d  = bg_i;
        end else if (shift_i) begin
            row_d = row_q << 1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q <= '0;
            fg_q  <= '0;
            bg_q  <= '0;
        end else begin
            row_q <= row_d;
            fg_q  <= fg_d;
            bg_q  <= bg_d;
        end
    end

    assign pixel_bit_o = load_i ? row_i[CHAR_W-1] : row_q[CHAR_W-1];
    assign fg_o        = load_i ? fg_i : fg_q;
    assign bg_o        = load_i ? bg_i : bg_q;

endmodule

// File: rtl/glyph_serializer.sv
// Text-mode glyph serializer: fetches one font row per character cell into a
// shadow register and shifts the active row out one coloured pixel per clock.
module glyph_serializer
    import glyph_serializer_pkg::*;
#(
    parameter int CHAR_W  = DEF_CHAR_W,
    parameter int COLOR_W = DEF_COLOR_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               line_start_i,
    input  logic               video_on_i,
    input  logic [CHAR_W-1:0]  font_data_i,
    input  logic               font_valid_i,
    input  logic [COLOR_W-1:0] attr_fg_i,
    input  logic [COLOR_W-1:0] attr_bg_i,
    input  logic               clr_err_i,
    output logic               fetch_req_o,
    output logic [COLOR_W-1:0] rgb_out_o,
    output logic               pixel_on_o,
    output logic               underrun_o,
    output logic               overrun_o
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   col_q, col_d;
    logic [CHAR_W-1:0]  shadowRow_q, shadowRow_d;
    logic [COLOR_W-1:0] shadowFg_q, shadowFg_d;
    logic [COLOR_W-1:0] shadowBg_q, shadowBg_d;
    logic               shadowFull_q, shadowFull_d;
    logic               reqPending_q, reqPending_d;
    logic               primeReq_q, primeReq_d;
    logic [COLOR_W-1:0] rgb_q, rgb_d;
    logic               pixelOn_q, pixelOn_d;
    logic               underrun_q, underrun_d;
    logic               overrun_q, overrun_d;

    logic               restart;
    logic               active;
    logic               cellStart;
    logic               shiftEn;
    logic               underrunSet;
    logic               overrunSet;
    logic [CHAR_W-1:0]  loadRow;
    logic [COLOR_W-1:0] loadFg;
    logic [COLOR_W-1:0] loadBg;
    logic               pixelBit;
    logic [COLOR_W-1:0] curFg;
    logic [COLOR_W-1:0] curBg;

    assign restart   = line_start_i && (state_q == ST_PRIME || state_q == ST_READY);
    assign active    = video_on_i && !restart && (state_q == ST_READY || state_q == ST_RUN);
    assign cellStart = active && (col_q == '0);
    assign shiftEn   = active && (col_q != '0);

    // An empty shadow at a cell start renders the whole cell as black background.
    assign loadRow = shadowFull_q ? shadowRow_q : '0;
    assign loadFg  = shadowFull_q ? shadowFg_q  : '0;
    assign loadBg  = shadowFull_q ? shadowBg_q  : COLOR_W'(COLOR_BLACK);

    assign underrunSet = cellStart && !shadowFull_q;
    assign overrunSet  = font_valid_i && shadowFull_q;

    glyph_shift_reg #(
        .CHAR_W  (CHAR_W),
        .COLOR_W (COLOR_W)
    ) u_shift (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (cellStart),
        .shift_i     (shiftEn),
        .row_i       (loadRow),
        .fg_i        (loadFg),
        .bg_i        (loadBg),
        .pixel_bit_o (pixelBit),
        .fg_o        (curFg),
        .bg_o        (curBg)
    );

    // A response arriving in a cell-start cycle is too late: the cell start clears the shadow.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        shadowRow_d  = shadowRow_q;
        shadowFg_d   = shadowFg_q;
        shadowBg_d   = shadowBg_q;
        shadowFull_d = shadowFull_q;
        reqPending_d = reqPending_q;
        primeReq_d   = 1'b0;

        if (font_valid_i && !shadowFull_q && reqPending_q) begin
            shadowRow_d  = font_data_i;
            shadowFg_d   = attr_fg_i;
            shadowBg_d   = attr_bg_i;
            shadowFull_d = 1'b1;
            reqPending_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (line_start_i) begin
                    state_d      = ST_PRIME;
                    primeReq_d   = 1'b1;
                    reqPending_d = 1'b1;
                    shadowFull_d = 1'b0;
                end
            end
            ST_PRIME: begin
                if (shadowFull_d) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (active) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!video_on_i) begin
                    state_d      = ST_IDLE;
                    shadowFull_d = 1'b0;
                    reqPending_d = 1'b0;
                    col_d        = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (active) begin
            col_d = CNT_W'(wrap_inc(int'(col_q), CHAR_W));
        end

        if (cellStart) begin
            shadowFull_d = 1'b0;
            reqPending_d = 1'b1;
        end

        if (restart) begin
            state_d      = ST_PRIME;
            shadowFull_d = 1'b0;
            reqPending_d = 1'b1;
            primeReq_d   = !primeReq_q;
        end
    end

    // Error flags: a set in the same cycle beats the clear.
    always_comb begin
        underrun_d = underrun_q;
        overrun_d  = overrun_q;
        if (clr_err_i) begin
            underrun_d = 1'b0;
            overrun_d  = 1'b0;
        end
        if (underrunSet) begin
            underrun_d = 1'b1;
        end
        if (overrunSet) begin
            overrun_d = 1'b1;
        end
    end

    assign rgb_d     = active ? (pixelBit ? curFg : curBg) : '0;
    assign pixelOn_d = active;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            shadowRow_q  <= '0;
            shadowFg_q   <= '0;
            shadowBg_q   <= '0;
            shadowFull_q <= 1'b0;
            reqPending_q <= 1'b0;
            primeReq_q   <= 1'b0;
            rgb_q        <= '0;
            pixelOn_q    <= 1'b0;
            underrun_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            shadowRow_q  <= shadowRow_d;
            shadowFg_q   <= shadowFg_d;
            shadowBg_q   <= shadowBg_d;
            shadowFull_q <= shadowFull_d;
            reqPending_q <= reqPending_d;
            primeReq_q   <= primeReq_d;
            rgb_q        <= rgb_d;
            pixelOn_q    <= pixelOn_d;
            underrun_q   <= underrun_d;
            overrun_q    <= overrun_d;
        end
    end

    assign fetch_req_o = primeReq_q || cellStart;
    assign rgb_out_o   = rgb_q;
    assign pixel_on_o  = pixelOn_q;
    assign underrun_o  = underrun_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_glyph_serializer.sv
// Randomised line-level bench for glyph_serializer: an automatic font responder
// drives each line while a per-cell reference model predicts the pixel stream.
module tb_glyph_serializer;

    localparam int CW   = 10;
    localparam int COLW = 8;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            line_start_i;
    logic            video_on_i;
    logic [CW-1:0]   font_data_i;
    logic            font_valid_i;
    logic [COLW-1:0] attr_fg_i;
    logic [COLW-1:0] attr_bg_i;
    logic            clr_err_i;
    logic            fetch_req_o;
    logic [COLW-1:0] rgb_out_o;
    logic            pixel_on_o;
    logic            underrun_o;
    logic            overrun_o;

    int errors = 0;
    int checks = 0;

    glyph_serializer #(
        .CHAR_W  (CW),
        .COLOR_W (COLW),
        .CNT_W   (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .line_start_i (line_start_i),
        .video_on_i   (video_on_i),
        .font_data_i  (font_data_i),
        .font_valid_i (font_valid_i),
        .attr_fg_i    (attr_fg_i),
        .attr_bg_i    (attr_bg_i),
        .clr_err_i    (clr_err_i),
        .fetch_req_o  (fetch_req_o),
        .rgb_out_o    (rgb_out_o),
        .pixel_on_o   (pixel_on_o),
        .underrun_o   (underrun_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk = ~clk;

    // Line description: request k carries the glyph for cell k (k=0 is the prime fetch).
    int              lineCells;
    int              vStart;
    int              dupReq;
    int              respDelay [16];
    logic [CW-1:0]   glyphRow  [16];
    logic [COLW-1:0] glyphFg   [16];
    logic [COLW-1:0] glyphBg   [16];

    typedef struct {
        int cyc;
        int req;
        bit dup;
    } resp_t;
    resp_t respQ[$];

    logic [COLW-1:0] obsPix[$];
    int obsFirstPix, obsLastPix, obsFetchInVideo, obsFetchTotal;
    int obsConsecFetch, obsIdleRgb, obsUnderrunFirst;

    // Reference model: a cell shows its glyph only if the response beat its start.
    function automatic int resp_cycle(input int k);
        if (k == 0) return 1 + respDelay[0];
        return vStart + CW * (k - 1) + respDelay[k];
    endfunction

    function automatic bit cell_has_glyph(input int k);
        return (respDelay[k] > 0) && (resp_cycle(k) < vStart + CW * k);
    endfunction

    function automatic logic [COLW-1:0] exp_pixel(input int k, input int i);
        logic [CW-1:0] row;
        row = glyphRow[k];
        if (!cell_has_glyph(k)) return 8'h00;
        return row[CW-1-i] ? glyphFg[k] : glyphBg[k];
    endfunction

    task automatic setup_random(input int cells);
        lineCells = cells;
        vStart    = 11 + int'($urandom_range(0, 9));
        dupReq    = -1;
        for (int k = 0; k < 16; k++) begin
            glyphRow[k]  = CW'($urandom);
            glyphFg[k]   = COLW'($urandom);
            glyphBg[k]   = COLW'($urandom);
            respDelay[k] = int'($urandom_range(1, 8));
        end
    endtask

    task automatic run_line(input int totalCycles);
        int    reqIdx;
        bit    prevFetch;
        resp_t rsp;
        respQ.delete();
        obsPix.delete();
        obsFirstPix = -1; obsLastPix = -1; obsFetchInVideo = 0; obsFetchTotal = 0;
        obsConsecFetch = 0; obsIdleRgb = 0; obsUnderrunFirst = -1;
        reqIdx = 0;
        prevFetch = 1'b0;
        for (int c = 0; c < totalCycles; c++) begin
            @(posedge clk);
            #1;
            line_start_i = (c == 0);
            video_on_i   = (c >= vStart) && (c < vStart + CW * lineCells);
            font_valid_i = 1'b0;
            font_data_i  = CW'($urandom);
            attr_fg_i    = COLW'($urandom);
            attr_bg_i    = COLW'($urandom);
            for (int i = respQ.size() - 1; i >= 0; i--) begin
                if (respQ[i].cyc == c) begin
                    font_valid_i = 1'b1;
                    font_data_i  = respQ[i].dup ? ~glyphRow[respQ[i].req] : glyphRow[respQ[i].req];
                    attr_fg_i    = respQ[i].dup ? ~glyphFg[respQ[i].req]  : glyphFg[respQ[i].req];
                    attr_bg_i    = respQ[i].dup ? ~glyphBg[respQ[i].req]  : glyphBg[respQ[i].req];
                    respQ.delete(i);
                end
            end
            @(negedge clk);
            if (fetch_req_o === 1'b1) begin
                if (prevFetch) obsConsecFetch++;
                obsFetchTotal++;
                if (video_on_i) obsFetchInVideo++;
                if (reqIdx < 16 && respDelay[reqIdx] > 0) begin
                    rsp.cyc = c + respDelay[reqIdx]; rsp.req = reqIdx; rsp.dup = 1'b0;
                    respQ.push_back(rsp);
                    if (dupReq == reqIdx) begin
                        rsp.cyc = c + respDelay[reqIdx] + 1; rsp.dup = 1'b1;
                        respQ.push_back(rsp);
                    end
                end
                reqIdx++;
            end
            prevFetch = (fetch_req_o === 1'b1);
            if (pixel_on_o === 1'b1) begin
                obsPix.push_back(rgb_out_o);
                if (obsFirstPix < 0) obsFirstPix = c;
                obsLastPix = c;
            end else if (rgb_out_o !== '0) begin
                obsIdleRgb++;
            end
            if (underrun_o === 1'b1 && obsUnderrunFirst < 0) obsUnderrunFirst = c;
        end
        line_start_i = 1'b0;
        video_on_i   = 1'b0;
        font_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; line_start_i = 1'b0; video_on_i = 1'b0; font_valid_i = 1'b0;
        font_data_i = '0; attr_fg_i = '0; attr_bg_i = '0; clr_err_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rgb_out_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_rgb got=%h exp=00", rgb_out_o); end
        checks++; if (pixel_on_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_pixel_on got=%b exp=0", pixel_on_o); end
        checks++; if (fetch_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch got=%b exp=0", fetch_req_o); end
        checks++; if (underrun_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_underrun got=%b exp=0", underrun_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun got=%b exp=0", overrun_o); end
        rst_ni = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single_cell();
        logic [COLW-1:0] expList [10];
        expList = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        setup_random(1);
        vStart = 12;
        glyphRow[0] = 10'b1000010000; glyphFg[0] = 8'hFF; glyphBg[0] = 8'h00;
        respDelay[0] = 2; respDelay[1] = 3;
        run_line(vStart + 25);
        checks++; if (obsPix.size() != 10) begin errors++; $display("[TB] FAIL single_count got=%0d exp=10", obsPix.size()); end
        for (int i = 0; i < 10 && i < obsPix.size(); i++) begin
            checks++;
            if (obsPix[i] !== expList[i]) begin errors++; $display("[TB] FAIL single_pix[%0d] got=%h exp=%h", i, obsPix[i], expList[i]); end
        end
        checks++; if (obsFirstPix != vStart + 1) begin errors++; $display("[TB] FAIL single_latency got=%0d exp=%0d", obsFirstPix, vStart + 1); end
        checks++; if (obsLastPix - obsFirstPix != 9) begin errors++; $display("[TB] FAIL single_span got=%0d exp=9", obsLastPix - obsFirstPix); end
        checks++; if (obsFetchTotal != 2) begin errors++; $display("[TB] FAIL single_fetches got=%0d exp=2", obsFetchTotal); end
        checks++; if (underrun_o !== 1'b0 || overrun_o !== 1'b0) begin errors++; $display("[TB] FAIL single_flags got=%b%b exp=00", underrun_o, overrun_o); end
    endtask

    task automatic test_alternating();
        setup_random(8);
        for (int k = 0; k < 9; k++) begin
            glyphRow[k]  = (k % 2 == 0) ? 10'h3FF : 10'h000;
            respDelay[k] = 3;
        end
        run_line(vStart + 80 + 15);
        checks++; if (obsPix.size() != 80) begin errors++; $display("[TB] FAIL alt_count got=%0d exp=80", obsPix.size()); end
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < CW; i++) begin
                if (k * CW + i < obsPix.size()) begin
                    checks++;
                    if (obsPix[k*CW+i] !== exp_pixel(k, i)) begin
                        errors++;
                        $display("[TB] FAIL alt_pix cell=%0d col=%0d got=%h exp=%h", k, i, obsPix[k*CW+i], exp_pixel(k, i));
                    end
                end
            end
        end
        checks++; if (obsLastPix - obsFirstPix != 79) begin errors++; $display("[TB] FAIL alt_contiguous got=%0d exp=79", obsLastPix - obsFirstPix); end
        checks++; if (obsFetchInVideo != 8) begin errors++; $display("[TB] FAIL alt_run_fetches got=%0d exp=8", obsFetchInVideo); end
        checks++; if (obsConsecFetch != 0) begin errors++; $display("[TB] FAIL alt_consec_fetch got=%0d exp=0", obsConsecFetch); end
        checks++; if (underrun_o !== 1'b0) begin errors++; $display("[TB] FAIL alt_underrun got=%b exp=0", underrun_o); end
    endtask

    task automatic test_random_lines();
        for (int n = 0; n < 4; n++) begin
            setup_random(int'($urandom_range(1, 6)));
            run_line(vStart + CW * lineCells + 15);
            checks++;
            if (obsPix.size() != CW * lineCells) begin errors++; $display("[TB] FAIL rand_count line=%0d got=%0d exp=%0d", n, obsPix.size(), CW * lineCells); end
            for (int k = 0; k < lineCells; k++) begin
                for (int i = 0; i < CW; i++) begin
                    if (k * CW + i < obsPix.size()) begin
                        checks++;
                        if (obsPix[k*CW+i] !== exp_pixel(k, i)) begin
                            errors++;
                            $display("[TB] FAIL rand_pix line=%0d cell=%0d col=%0d got=%h exp=%h", n, k, i, obsPix[k*CW+i], exp_pixel(k, i));
                        end
                    end
                end
            end
            checks++; if (obsIdleRgb != 0) begin errors++; $display("[TB] FAIL rand_idle_rgb line=%0d got=%0d exp=0", n, obsIdleRgb); end
            checks++; if (underrun_o !== 1'b0 || overrun_o !== 1'b0) begin errors++; $display("[TB] FAIL rand_flags line=%0d got=%b%b exp=00", n, underrun_o, overrun_o); end
        end
    endtask

    task automatic test_underrun();
        setup_random(6);
        respDelay[3] = 0;
        run_line(vStart + 60 + 15);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < CW; i++) begin
                if (k * CW + i < obsPix.size()) begin
                    checks++;
                    if (obsPix[k*CW+i] !== exp_pixel(k, i)) begin
                        errors++;
                        $display("[TB] FAIL under_pix cell=%0d col=%0d got=%h exp=%h", k, i, obsPix[k*CW+i], exp_pixel(k, i));
                    end
                end
            end
        end
        checks++; if (obsPix.size() != 60) begin errors++; $display("[TB] FAIL under_count got=%0d exp=60", obsPix.size()); end
        checks++; if (obsUnderrunFirst != vStart + 31) begin errors++; $display("[TB] FAIL under_set_cycle got=%0d exp=%0d", obsUnderrunFirst, vStart + 31); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("[TB] FAIL under_overrun got=%b exp=0", overrun_o); end
        @(posedge clk); #1 clr_err_i = 1'b1;
        @(negedge clk);
        checks++; if (underrun_o !== 1'b1) begin errors++; $display("[TB] FAIL under_hold_before_clr got=%b exp=1", underrun_o); end
        @(posedge clk); #1 clr_err_i = 1'b0;
        @(negedge clk);
        checks++; if (underrun_o !== 1'b0) begin errors++; $display("[TB] FAIL under_clear got=%b exp=0", underrun_o); end
    endtask

    task automatic test_overrun();
        setup_random(4);
        dupReq = 2;
        run_line(vStart + 40 + 15);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < CW; i++) begin
                if (k * CW + i < obsPix.size()) begin
                    checks++;
                    if (obsPix[k*CW+i] !== exp_pixel(k, i)) begin
                        errors++;
                        $display("[TB] FAIL over_pix cell=%0d col=%0d got=%h exp=%h", k, i, obsPix[k*CW+i], exp_pixel(k, i));
                    end
                end
            end
        end
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("[TB] FAIL over_flag got=%b exp=1", overrun_o); end
        checks++; if (underrun_o !== 1'b0) begin errors++; $display("[TB] FAIL over_underrun got=%b exp=0", underrun_o); end
        @(posedge clk); #1 clr_err_i = 1'b1;
        @(posedge clk); #1 clr_err_i = 1'b0;
        @(negedge clk);
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("[TB] FAIL over_clear got=%b exp=0", overrun_o); end
    endtask

    task automatic test_reset_mid_cell();
        int fetchSeen;
        int pixSeen;
        setup_random(4);
        vStart = 12;
        respDelay[1] = 0;
        run_line(vStart + 25);
        video_on_i = 1'b1;
        @(posedge clk); #2;
        checks++; if (pixel_on_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_pixel_on got=%b exp=1", pixel_on_o); end
        checks++; if (underrun_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_underrun got=%b exp=1", underrun_o); end
        #1 rst_ni = 1'b0;
        #1;
        checks++; if (rgb_out_o !== 8'h00) begin errors++; $display("[TB] FAIL midrst_rgb got=%h exp=00", rgb_out_o); end
        checks++; if (pixel_on_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pixel_on got=%b exp=0", pixel_on_o); end
        checks++; if (fetch_req_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_fetch got=%b exp=0", fetch_req_o); end
        checks++; if (underrun_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_underrun got=%b exp=0", underrun_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_overrun got=%b exp=0", overrun_o); end
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        fetchSeen = 0;
        pixSeen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (fetch_req_o === 1'b1) fetchSeen++;
            if (pixel_on_o === 1'b1) pixSeen++;
        end
        video_on_i = 1'b0;
        checks++; if (fetchSeen != 0) begin errors++; $display("[TB] FAIL midrst_no_fetch got=%0d exp=0", fetchSeen); end
        checks++; if (pixSeen != 0) begin errors++; $display("[TB] FAIL midrst_no_pixels got=%0d exp=0", pixSeen); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_video_drop();
        setup_random(2);
        respDelay[0] = 2; respDelay[1] = 4; respDelay[2] = 13;
        run_line(vStart + 20 + 20);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < CW; i++) begin
                if (k * CW + i < obsPix.size()) begin
                    checks++;
                    if (obsPix[k*CW+i] !== exp_pixel(k, i)) begin
                        errors++;
                        $display("[TB] FAIL drop_pix cell=%0d col=%0d got=%h exp=%h", k, i, obsPix[k*CW+i], exp_pixel(k, i));
                    end
                end
            end
        end
        checks++; if (obsPix.size() != 20) begin errors++; $display("[TB] FAIL drop_count got=%0d exp=20", obsPix.size()); end
        checks++; if (obsIdleRgb != 0) begin errors++; $display("[TB] FAIL drop_idle_rgb got=%0d exp=0", obsIdleRgb); end
        checks++; if (underrun_o !== 1'b0 || overrun_o !== 1'b0) begin errors++; $display("[TB] FAIL drop_flags got=%b%b exp=00", underrun_o, overrun_o); end
        setup_random(3);
        run_line(vStart + 30 + 15);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < CW; i++) begin
                if (k * CW + i < obsPix.size()) begin
                    checks++;
                    if (obsPix[k*CW+i] !== exp_pixel(k, i)) begin
                        errors++;
                        $display("[TB] FAIL drop_next_pix cell=%0d col=%0d got=%h exp=%h", k, i, obsPix[k*CW+i], exp_pixel(k, i));
                    end
                end
            end
        end
        checks++; if (obsPix.size() != 30) begin errors++; $display("[TB] FAIL drop_next_count got=%0d exp=30", obsPix.size()); end
        checks++; if (underrun_o !== 1'b0 || overrun_o !== 1'b0) begin errors++; $display("[TB] FAIL drop_next_flags got=%b%b exp=00", underrun_o, overrun_o); end
    endtask

    initial begin
        test_reset();
        test_single_cell();
        test_alternating();
        test_random_lines();
        test_underrun();
        test_overrun();
        test_reset_mid_cell();
        test_video_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/glyph_serializer.md
Name: glyph_serializer

Overview:
- Downstream of the font ROM in the text-mode video path.
- Each character cell it requests one glyph row, CHAR_W bits wide, and latches it with that character's colour attributes.
- It then shifts the row out one pixel per clock as a colour value for the VGA output stage.
- Double buffering (shadow row + active shifter) lets the next glyph fetch overlap the current cell.

Parameters:
- CHAR_W, 10, glyph row width in pixels (font row bits).
- COLOR_W, 8, pixel colour width (RGB332).
- CNT_W, 4, width of the in-cell column counter; must satisfy 2^CNT_W >= CHAR_W.

Ports:
- CLK  in  1  pixel clock; all state on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- LINE_START  in  1  one-cycle pulse at least CHAR_W cycles before the first VIDEO_ON cycle of a text scanline.
- VIDEO_ON  in  1  high for every active-pixel cycle of the line; the run length is a multiple of CHAR_W.
- FONT_DATA  in  CHAR_W  glyph row from the font ROM; bit CHAR_W-1 is the leftmost pixel.
- FONT_VALID  in  1  FONT_DATA, ATTR_FG and ATTR_BG are valid this cycle.
- ATTR_FG  in  COLOR_W  foreground colour for the fetched character.
- ATTR_BG  in  COLOR_W  background colour for the fetched character.
- CLR_ERR  in  1  synchronous clear of the sticky error flags.
- FETCH_REQ  out  1  one-cycle pulse requesting the next glyph row.
- RGB_OUT  out  COLOR_W  registered pixel colour.
- PIXEL_ON  out  1  registered; RGB_OUT is an active pixel.
- UNDERRUN  out  1  sticky: a cell started with no glyph loaded.
- OVERRUN  out  1  sticky: FONT_VALID arrived while the shadow was full.

Behaviour:
- Reset (asynchronous, any state, including mid-line):
  - Outputs: RGB_OUT=0, PIXEL_ON=0, FETCH_REQ=0, UNDERRUN=0, OVERRUN=0.
  - Internal: state=IDLE, shadow_full=0, req_pending=0, col=0.
- FSM states: IDLE, PRIME, READY, RUN.
- IDLE:
  - RGB_OUT=0, PIXEL_ON=0.
  - LINE_START -> PRIME, with FETCH_REQ=1 in the next cycle and req_pending=1.
- PRIME:
  - Waits for FONT_VALID while req_pending=1.
  - On FONT_VALID: load shadow row/FG/BG, shadow_full=1, req_pending=0 -> READY.
- READY:
  - Holds.
  - The first VIDEO_ON cycle acts as a cell start (col=0) -> RUN.
- RUN, cell start (VIDEO_ON=1 and col=0):
  - Shifter <= shadow, shadow_full <= 0.
  - FETCH_REQ=1 in the same cycle; req_pending=1.
  - If shadow_full=0 at the cell start: shifter loads all zeros with BG=0, and UNDERRUN<=1.
- RUN, every VIDEO_ON cycle:
  - col increments, wrapping at CHAR_W-1 -> 0.
  - The pixel for cycle t appears on RGB_OUT/PIXEL_ON at t+1 (fixed latency 1).
  - The pixel value is FG when the current shifter bit (MSB first) is 1, else BG.
- FONT_VALID handling:
  - With req_pending=1 and shadow_full=0: load shadow, clear req_pending.
  - With shadow_full=1: ignored, OVERRUN<=1.
  - With req_pending=0: ignored, no flag.
  - The upstream response deadline is CHAR_W-1 cycles after FETCH_REQ; a later response that misses the next cell start counts as an underrun for that cell.
- VIDEO_ON falling edge in RUN:
  - Next state IDLE.
  - Shadow and req_pending are discarded.
  - PIXEL_ON=0 and RGB_OUT=0 from the following cycle.
  - The final in-flight pixel still emits.
- LINE_START while RUN: ignored.
- LINE_START in PRIME/READY: restarts the prime (shadow cleared, new FETCH_REQ).
- CLR_ERR:
  - Clears UNDERRUN/OVERRUN next cycle.
  - A same-cycle set event takes priority over the clear.
- FETCH_REQ is never asserted on two consecutive cycles.
- A trailing FETCH_REQ at the last cell of a line is allowed; its response is discarded in IDLE.

Decomposition:
- Shared video package holds:
  - CHAR_W and COLOR_W defaults, shared with the font ROM and colour output stage.
  - FSM state encoding constants (IDLE/PRIME/READY/RUN, 2-bit).
  - Default colour constants (COLOR_BLACK=8'h00, COLOR_WHITE=8'hFF).
- One natural sub-module: glyph_shift_reg.
  - Parallel-load, MSB-first shifter carrying FG/BG alongside the row.
  - Instantiated once for the active path; the shadow row is plain registers.

Test Plan:
- Reset release, LINE_START, FONT_VALID 2 cycles after FETCH_REQ with FONT_DATA=10'b1000010000, FG=8'hFF, BG=8'h00, then VIDEO_ON for 10 cycles -> RGB_OUT FF,00,00,00,00,FF,00,00,00,00 starting 1 cycle after the first VIDEO_ON; PIXEL_ON high exactly 10 cycles.
- 8-cell line, each response 3 cycles after FETCH_REQ with alternating patterns 10'h3FF / 10'h000 -> 80 contiguous pixels, all-FG and all-BG cells alternate, UNDERRUN=0, exactly 8 FETCH_REQ pulses in RUN.
- Withhold FONT_VALID for cell 3 -> cell 3 outputs 10 pixels of 8'h00, UNDERRUN=1 from the cell-3 start until CLR_ERR; cell 4 renders normally.
- Two FONT_VALID pulses for one request -> the second sets OVERRUN=1, the displayed glyph equals the first response.
- Assert RESET low mid-cell (col=5) -> all outputs 0 asynchronously; after release, no FETCH_REQ until the next LINE_START.
- VIDEO_ON drops after 2 cells with a fetch outstanding; the late FONT_VALID arrives in IDLE -> no flags, RGB_OUT=0, and the next line primes cleanly.
